hdlverifier_capture_trigger_seq: RTL and testbench



---
 rtl/hdlverifier_capture_pkg.sv | 21 ++
 rtl/hdlverifier_capture_stage_cmp.sv | 55 +++++
 rtl/hdlverifier_capture_trigger_seq.sv | 125 ++++++++++++
 tb/tb_hdlverifier_capture_trigger_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlverifier_capture_pkg.sv
// Shared types and constants for the capture trigger sequencer.
package hdlverifier_capture_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_EQ     = 3'd0;
  localparam logic [MODE_W-1:0] MODE_NE     = 3'd1;
  localparam logic [MODE_W-1:0] MODE_GT     = 3'd2;
  localparam logic [MODE_W-1:0] MODE_LT     = 3'd3;
  localparam logic [MODE_W-1:0] MODE_RISE   = 3'd4;
  localparam logic [MODE_W-1:0] MODE_CHANGE = 3'd5;
  localparam logic [MODE_W-1:0] MODE_ALWAYS = 3'd6;
  localparam logic [MODE_W-1:0] MODE_NEVER  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2
  } state_e;

endpackage

// File: rtl/hdlverifier_capture_stage_cmp.sv
// One masked comparator stage; match is registered one enabled
// cycle after the sample it describes.
module hdlverifier_capture_stage_cmp
  import hdlverifier_capture_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic [WIDTH-1:0]  data,
  input  logic [WIDTH-1:0]  value,
  input  logic [WIDTH-1:0]  mask,
  input  logic [MODE_W-1:0] mode,
  output logic              match
);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic             match_q, match_d;
  logic [WIDTH-1:0] m_d, m_v, m_p;
  logic             hit;

  always_comb begin
    m_d = data & mask;
    m_v = value & mask;
    m_p = prev_q & mask;
    hit = 1'b0;
    unique case (mode)
      MODE_EQ:     hit = (m_d == m_v);
      MODE_NE:     hit = (m_d != m_v);
      MODE_GT:     hit = (m_d > m_v);
      MODE_LT:     hit = (m_d < m_v);
      MODE_RISE:   hit = (m_d == m_v) && (m_p != m_v);
      MODE_CHANGE: hit = (m_d != m_p);
      MODE_ALWAYS: hit = 1'b1;
      MODE_NEVER:  hit = 1'b0;
      default:     hit = 1'b0;
    endcase
    prev_d  = clk_enable ? data : prev_q;
    match_d = clk_enable ? hit : match_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= '0;
      match_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;

endmodule

// File: rtl/hdlverifier_capture_trigger_seq.sv
// Multi-stage sequential capture trigger: ordered stages, each with
// a mode compare and a cumulative occurrence count.
module hdlverifier_capture_trigger_seq
  import hdlverifier_capture_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_STAGES = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int SW         = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clk_enable,
  input  logic [WIDTH-1:0]               data,
  input  logic                           arm,
  input  logic                           abort,
  input  logic [NUM_STAGES*WIDTH-1:0]    cfg_value,
  input  logic [NUM_STAGES*WIDTH-1:0]    cfg_mask,
  input  logic [NUM_STAGES*MODE_W-1:0]   cfg_mode,
  input  logic [NUM_STAGES*CNT_WIDTH-1:0] cfg_count,
  input  logic [SW-1:0]                  cfg_last_stage,
  output logic                           trigger,
  output logic                           triggered,
  output logic                           armed,
  output logic [SW-1:0]                  stage
);

  localparam int LAST_MAX = NUM_STAGES - 1;

  logic [NUM_STAGES-1:0] match;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_cmp
    hdlverifier_capture_stage_cmp #(.WIDTH(WIDTH)) u_cmp (
      .clk        (clk),
      .reset      (reset),
      .clk_enable (clk_enable),
      .data       (data),
      .value      (cfg_value[k*WIDTH +: WIDTH]),
      .mask       (cfg_mask[k*WIDTH +: WIDTH]),
      .mode       (cfg_mode[k*MODE_W +: MODE_W]),
      .match      (match[k])
    );
  end

  state_e               state_q, state_d;
  logic [SW-1:0]        stage_q, stage_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 trigger_q, trigger_d;
  logic                 triggered_q, triggered_d;

  logic                 sel_match;
  logic [CNT_WIDTH-1:0] sel_count;
  logic [SW-1:0]        last_stage;

  always_comb begin
    sel_match = 1'b0;
    sel_count = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (stage_q == SW'(k)) begin
        sel_match = match[k];
        sel_count = cfg_count[k*CNT_WIDTH +: CNT_WIDTH];
      end
    end
    last_stage = (32'(cfg_last_stage) > LAST_MAX) ? SW'(LAST_MAX)
                                                  : cfg_last_stage;
  end

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    cnt_d       = cnt_q;
    trigger_d   = trigger_q;
    triggered_d = triggered_q;
    if (clk_enable) begin
      trigger_d = 1'b0;
      if (abort) begin
        state_d     = ST_IDLE;
        stage_d     = '0;
        cnt_d       = '0;
        triggered_d = 1'b0;
      end else if (arm) begin
        state_d     = ST_ARMED;
        stage_d     = '0;
        cnt_d       = '0;
        triggered_d = 1'b0;
      end else if (state_q == ST_ARMED && sel_match) begin
        if (cnt_q == sel_count) begin
          cnt_d = '0;
          // >= keeps a shrunk last-stage config from running away
          if (stage_q >= last_stage) begin
            state_d     = ST_TRIGGERED;
            trigger_d   = 1'b1;
            triggered_d = 1'b1;
          end else begin
            stage_d = stage_q + SW'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      stage_q     <= '0;
      cnt_q       <= '0;
      trigger_q   <= 1'b0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      cnt_q       <= cnt_d;
      trigger_q   <= trigger_d;
      triggered_q <= triggered_d;
    end
  end

  assign trigger   = trigger_q;
  assign triggered = triggered_q;
  assign armed     = (state_q == ST_ARMED);
  assign stage     = stage_q;

endmodule

// File: tb/tb_hdlverifier_capture_trigger_seq.sv
// Scoreboard bench for the capture trigger sequencer with a
// behavioural model and randomized traffic after directed cases.
module tb_hdlverifier_capture_trigger_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic [7:0]  data = '0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_value = '0;
  logic [31:0] cfg_mask = '0;
  logic [11:0] cfg_mode = '0;
  logic [63:0] cfg_count = '0;
  logic [2:0]  cfg_last_stage = '0;
  logic        trigger, triggered, armed;
  logic [2:0]  stage;

  hdlverifier_capture_trigger_seq dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .data(data),
    .arm(arm), .abort(abort), .cfg_value(cfg_value),
    .cfg_mask(cfg_mask), .cfg_mode(cfg_mode), .cfg_count(cfg_count),
    .cfg_last_stage(cfg_last_stage), .trigger(trigger),
    .triggered(triggered), .armed(armed), .stage(stage)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int trig_seen = 0;
  logic [5:0] exp_q[$];

  function automatic void chk(string n, logic [31:0] got,
                              logic [31:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp,
               $time);
    else
      passes++;
  endfunction

  // reference model: 0 idle, 1 armed, 2 triggered
  int         m_state;
  int         m_stage;
  int         m_cnt;
  bit         m_trig, m_trigd;
  logic [7:0] m_prev;
  bit         m_hit_prev[4];

  function automatic bit hit(int k, logic [7:0] d, logic [7:0] p);
    int md, mv, mp;
    md = int'(d & cfg_mask[k*8 +: 8]);
    mv = int'(cfg_value[k*8 +: 8] & cfg_mask[k*8 +: 8]);
    mp = int'(p & cfg_mask[k*8 +: 8]);
    case (int'(cfg_mode[k*3 +: 3]))
      0: return md == mv;
      1: return md != mv;
      2: return md > mv;
      3: return md < mv;
      4: return (md == mv) && (mp != mv);
      5: return md != mp;
      6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    m_state = 0; m_stage = 0; m_cnt = 0;
    m_trig = 0; m_trigd = 0; m_prev = '0;
    for (int k = 0; k < 4; k++) m_hit_prev[k] = 0;
  endfunction

  function automatic void model_tick(logic [7:0] d, bit en, bit a,
                                     bit ab);
    bit now_hit[4];
    int last;
    if (!en) return;
    last = (int'(cfg_last_stage) > 3) ? 3 : int'(cfg_last_stage);
    for (int k = 0; k < 4; k++) now_hit[k] = hit(k, d, m_prev);
    m_trig = 0;
    if (ab) begin
      m_state = 0; m_stage = 0; m_cnt = 0; m_trigd = 0;
    end else if (a) begin
      m_state = 1; m_stage = 0; m_cnt = 0; m_trigd = 0;
    end else if (m_state == 1 && m_hit_prev[m_stage]) begin
      if (m_cnt == int'(cfg_count[m_stage*16 +: 16])) begin
        m_cnt = 0;
        if (m_stage == last) begin
          m_state = 2; m_trig = 1; m_trigd = 1;
        end else begin
          m_stage++;
        end
      end else begin
        m_cnt++;
      end
    end
    m_hit_prev = now_hit;
    m_prev = d;
  endfunction

  function automatic logic [5:0] model_out();
    return {m_trig, m_trigd, m_state == 1, 3'(m_stage)};
  endfunction

  task automatic step(input logic [7:0] d, input bit en = 1,
                      input bit a = 0, input bit ab = 0);
    data = d; clk_enable = en; arm = a; abort = ab;
    @(posedge clk);
    if (reset) model_reset();
    else model_tick(d, en, a, ab);
    exp_q.push_back(model_out());
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
  endtask

  task automatic set_stage(int k, logic [7:0] v, logic [7:0] m,
                           logic [2:0] md, logic [15:0] c);
    cfg_value[k*8 +: 8] = v;
    cfg_mask[k*8 +: 8] = m;
    cfg_mode[k*3 +: 3] = md;
    cfg_count[k*16 +: 16] = c;
  endtask

  // monitor: compares every cycle the stimulus has scored
  initial begin
    logic [5:0] e;
    logic prev_trig = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("outputs", {26'd0, trigger, triggered, armed, stage},
            {26'd0, e});
      end
      if (trigger && !prev_trig) trig_seen++;
      prev_trig = trigger;
    end
  end

  initial begin
    int t0;
    model_reset();
    #1;
    chk("reset_state", {trigger, triggered, armed, stage}, 6'd0);
    @(negedge clk);
    step(8'h00);
    reset = 1'b0;
    step(8'h00);

    // single stage EQ
    cfg_last_stage = 3'd0;
    set_stage(0, 8'h5A, 8'hFF, 3'd0, 16'd0);
    t0 = trig_seen;
    step(8'h00, 1, 1);
    step(8'h5A);
    chk("t1_no_early", trigger, 1'b0);
    step(8'h00);
    chk("t1_pulse", trigger, 1'b1);
    step(8'h00);
    chk("t1_pulse_end", {trigger, triggered}, 2'b01);
    chk("t1_count", trig_seen - t0, 1);

    // two stages with occurrence count
    cfg_last_stage = 3'd1;
    set_stage(0, 8'h10, 8'hFF, 3'd0, 16'd2);
    set_stage(1, 8'h80, 8'hFF, 3'd2, 16'd0);
    t0 = trig_seen;
    step(8'h00, 1, 1);
    step(8'h10); step(8'h33); step(8'h10); step(8'h10);
    chk("t2_stage0", stage, 3'd0);
    step(8'h90);
    chk("t2_stage1", {trigger, stage}, 4'b0001);
    step(8'h00);
    chk("t2_pulse", trigger, 1'b1);
    chk("t2_count", trig_seen - t0, 1);

    // masked RISE
    cfg_last_stage = 3'd0;
    set_stage(0, 8'h01, 8'h01, 3'd4, 16'd0);
    t0 = trig_seen;
    step(8'h02, 1, 1); step(8'h03); step(8'h05); step(8'h05);
    chk("t3_rise", trig_seen - t0, 1);
    t0 = trig_seen;
    step(8'h05, 1, 1); step(8'h05); step(8'h05);
    chk("t3_no_rise", {trig_seen - t0, 1'b0, armed}, 33'd1);

    // clk_enable gating
    cfg_last_stage = 3'd1;
    set_stage(0, 8'h10, 8'hFF, 3'd0, 16'd3);
    set_stage(1, 8'h20, 8'hFF, 3'd0, 16'd0);
    step(8'h10, 1, 1); step(8'h10);
    step(8'h10, 0); step(8'h10, 0); step(8'h10, 0);
    step(8'h10);
    chk("t4_gated", stage, 3'd0);

    // abort and arm together at stage 1
    step(8'h10, 1, 1);
    repeat (4) step(8'h10);
    chk("t5_at1", stage, 3'd1);
    step(8'h00, 1, 1, 1);
    chk("t5_abort", {armed, stage}, 4'd0);
    step(8'h10, 1, 1);
    repeat (4) step(8'h10);
    step(8'h20); step(8'h00);
    chk("t5_trig", triggered, 1'b1);
    step(8'h00, 1, 1);
    chk("t5_rearm", {triggered, armed, stage}, 5'b01000);

    // async reset mid-sequence
    cfg_last_stage = 3'd3;
    for (int k = 0; k < 3; k++) set_stage(k, 8'h00, 8'h00, 3'd6, 16'd0);
    set_stage(3, 8'h00, 8'h00, 3'd7, 16'd0);
    step(8'h00, 1, 1); step(8'h00); step(8'h00);
    chk("t6_at2", stage, 3'd2);
    t0 = trig_seen;
    #2 reset = 1'b1;
    #1 chk("t6_async", {trigger, triggered, armed, stage}, 6'd0);
    @(negedge clk);
    step(8'h00);
    reset = 1'b0;
    repeat (4) step(8'h00);
    chk("t6_no_trig", trig_seen - t0, 0);

    // randomized traffic
    step(8'h00, 1, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      bit en, a, ab;
      if (m_state == 0 && $urandom_range(7) == 0) begin
        for (int k = 0; k < 4; k++)
          set_stage(k, 8'($urandom),
                    ($urandom_range(1) != 0) ? 8'hFF : 8'($urandom),
                    3'($urandom_range(7)), 16'($urandom_range(2)));
        cfg_last_stage = 3'($urandom_range(7));
      end
      if ($urandom_range(3) == 0) d = 8'($urandom);
      else d = cfg_value[$urandom_range(3)*8 +: 8];
      en = ($urandom_range(7) != 0);
      a = (m_state == 0) ? ($urandom_range(3) == 0)
                         : ($urandom_range(39) == 0);
      ab = ($urandom_range(59) == 0);
      step(d, en, a, ab);
    end
    step(8'h00);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
